// File: rtl/upc_marquee.sv
// upc_marquee: latches a UPC code and shows its breed name on active-low seven-segment digits,
// static when it fits, scrolling when it does not, blinking "Err" for invalid codes.
module upc_marquee #(
  parameter int NUM_DIGITS = 6,
  parameter int SCROLL_DIV = 25000000,
  parameter int GAP        = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              upc,
  input  logic                    upc_load,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    scrolling,
  output logic                    wrap_pulse
);
  localparam int MAX_S = 7 + GAP;
  localparam int PW    = $clog2(MAX_S);
  localparam int CW    = $clog2(SCROLL_DIV);

  typedef enum logic [1:0] {IDLE, STATIC, SCROLL, ERROR} state_t;

  function automatic int name_len(input logic [2:0] c);
    return (c == 3'd3 || c == 3'd4) ? 4 : (c == 3'd5) ? 6 : (c == 3'd2 || c == 3'd7) ? 3 : 7;
  endfunction

  // Invalid codes carry "Err" as their text so ERROR reuses the right-justified path.
  function automatic logic [55:0] name_txt(input logic [2:0] c);
    case (c)
      3'd0:    return "SIAMESE";
      3'd1:    return "PERSIAN";
      3'd3:    return {24'd0, "COON"};
      3'd4:    return {24'd0, "FOLD"};
      3'd5:    return {8'd0, "BENGAL"};
      3'd6:    return "RAGDOLL";
      default: return {32'd0, "Err"};
    endcase
  endfunction

  function automatic logic [6:0] seg(input logic [7:0] ch);
    case (ch)
      "A":     return 7'b0001000;
      "B":     return 7'b0000011;
      "C":     return 7'b1000110;
      "D":     return 7'b0100001;
      "E":     return 7'b0000110;
      "F":     return 7'b0001110;
      "G":     return 7'b0010000;
      "I":     return 7'b1001111;
      "L":     return 7'b1000111;
      "M":     return 7'b1001000;
      "N":     return 7'b1001000;
      "O":     return 7'b1000000;
      "P":     return 7'b0001100;
      "R":     return 7'b1001110;
      "S":     return 7'b0010010;
      "r":     return 7'b0101111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] glyph_at(input logic [2:0] c, input int j);
    int          n;
    logic [55:0] t;
    n = name_len(c);
    t = name_txt(c);
    if (j < 0 || j >= n) return 7'b1111111;
    return seg(t[8*(n-1-j) +: 8]);
  endfunction

  state_t                  r_state, w_next;
  logic [2:0]              r_code;
  logic [PW-1:0]           r_pos;
  logic [CW-1:0]           r_cnt;
  logic                    r_phase, r_pend, r_wrap, r_scr;
  logic [7*NUM_DIGITS-1:0] r_hex, w_frame;
  int                      w_len, w_s, w_j;
  logic                    w_tick, w_last;

  assign w_len  = name_len(r_code);
  assign w_s    = w_len + GAP;
  assign w_tick = r_cnt == CW'(SCROLL_DIV - 1);
  assign w_last = int'(r_pos) == w_s - 1;

  always_comb begin
    w_next = r_state;
    if (upc_load)
      w_next = (upc == 3'd2 || upc == 3'd7) ? ERROR : (name_len(upc) > NUM_DIGITS) ? SCROLL : STATIC;
  end

  // Digit 0 is leftmost; scrolling indexes the name+gap stream, otherwise right-justify.
  always_comb begin
    w_frame = '1;
    w_j     = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_j = (r_state == SCROLL) ? int'(r_pos) + i : i - (NUM_DIGITS - w_len);
      if (r_state == SCROLL && w_j >= w_s) w_j = w_j - w_s;
      if (r_state == SCROLL || r_state == STATIC || (r_state == ERROR && r_phase))
        w_frame[7*(NUM_DIGITS-1-i) +: 7] = glyph_at(r_code, w_j);
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_code  <= '0;
      r_pos   <= '0;
      r_cnt   <= '0;
      r_phase <= 1'b1;
      r_pend  <= 1'b0;
      r_wrap  <= 1'b0;
      r_scr   <= 1'b0;
      r_hex   <= '1;
    end else begin
      r_hex  <= w_frame;
      r_scr  <= r_state == SCROLL;
      r_wrap <= r_pend;
      r_pend <= 1'b0;
      if (upc_load) begin
        r_code  <= upc;
        r_pos   <= '0;
        r_cnt   <= '0;
        r_phase <= 1'b1;
      end else if (r_state == SCROLL || r_state == ERROR) begin
        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        if (w_tick && r_state == SCROLL) begin
          r_pos  <= w_last ? '0 : r_pos + 1'b1;
          r_pend <= w_last;
        end
        if (w_tick && r_state == ERROR) r_phase <= ~r_phase;
      end
    end
  end

  assign hex        = r_hex;
  assign scrolling  = r_scr;
  assign wrap_pulse = r_wrap;
endmodule

// File: tb/tb_upc_marquee.sv
// tb_upc_marquee: directed checks of upc_marquee with 4 digits, 4-cycle ticks and a 2-blank gap.
module tb_upc_marquee;
  localparam logic [6:0] G_A = 7'b0001000, G_B = 7'b0000011, G_C = 7'b1000110, G_D = 7'b0100001;
  localparam logic [6:0] G_E = 7'b0000110, G_F = 7'b0001110, G_G = 7'b0010000, G_I = 7'b1001111;
  localparam logic [6:0] G_L = 7'b1000111, G_M = 7'b1001000, G_N = 7'b1001000, G_O = 7'b1000000;
  localparam logic [6:0] G_P = 7'b0001100, G_R = 7'b1001110, G_S = 7'b0010010, G_r = 7'b0101111;
  localparam logic [6:0] G__ = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  upc = 3'd0;
  logic        upc_load = 1'b0;
  logic [27:0] hex;
  logic        scrolling, wrap_pulse;
  int          total = 0;
  int          bad = 0;

  upc_marquee #(.NUM_DIGITS(4), .SCROLL_DIV(4), .GAP(2)) dut (
    .clk(clk), .reset_n(reset_n), .upc(upc), .upc_load(upc_load),
    .hex(hex), .scrolling(scrolling), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [2:0] code);
    @(negedge clk);
    upc = code;
    upc_load = 1'b1;
    @(negedge clk);
    upc_load = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    wait_edges(3);
    total++; if (hex !== 28'hFFFFFFF) begin bad++; $display("FAIL reset_hex got=%h want=%h", hex, 28'hFFFFFFF); end
    total++; if (scrolling !== 1'b0) begin bad++; $display("FAIL reset_scrolling got=%b want=0", scrolling); end
    total++; if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap_pulse); end
    reset_n = 1'b1;
    wait_edges(2);
    total++; if (hex !== 28'hFFFFFFF) begin bad++; $display("FAIL idle_hex got=%h want=%h", hex, 28'hFFFFFFF); end
  endtask

  task automatic test_static;
    logic [27:0] exp_f;
    exp_f = {G_C, G_O, G_O, G_N};
    do_load(3'd3);
    wait_edges(1);
    total++; if (hex !== exp_f) begin bad++; $display("FAIL static_coon got=%h want=%h", hex, exp_f); end
    total++; if (scrolling !== 1'b0) begin bad++; $display("FAIL static_scrolling got=%b want=0", scrolling); end
    for (int k = 0; k < 40; k++) begin
      wait_edges(1);
      total++; if (hex !== exp_f || wrap_pulse !== 1'b0) begin bad++; $display("FAIL static_hold k=%0d got=%h/%b want=%h/0", k, hex, wrap_pulse, exp_f); end
    end
  endtask

  task automatic test_scroll;
    int n_wrap;
    n_wrap = 0;
    do_load(3'd0);
    wait_edges(1);
    total++; if (hex !== {G_S, G_I, G_A, G_M}) begin bad++; $display("FAIL scroll_f0 got=%h want=%h", hex, {G_S, G_I, G_A, G_M}); end
    total++; if (scrolling !== 1'b1) begin bad++; $display("FAIL scroll_flag got=%b want=1", scrolling); end
    total++; if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL scroll_nowrap_f0 got=%b want=0", wrap_pulse); end
    wait_edges(4);
    total++; if (hex !== {G_I, G_A, G_M, G_E}) begin bad++; $display("FAIL scroll_f1 got=%h want=%h", hex, {G_I, G_A, G_M, G_E}); end
    wait_edges(4);
    total++; if (hex !== {G_A, G_M, G_E, G_S}) begin bad++; $display("FAIL scroll_f2 got=%h want=%h", hex, {G_A, G_M, G_E, G_S}); end
    for (int k = 10; k <= 38; k++) begin
      wait_edges(1);
      if (wrap_pulse === 1'b1) n_wrap++;
      if (k == 33) begin
        total++; if (hex !== {G__, G_S, G_I, G_A}) begin bad++; $display("FAIL scroll_f8 got=%h want=%h", hex, {G__, G_S, G_I, G_A}); end
      end
      if (k == 37) begin
        total++; if (hex !== {G_S, G_I, G_A, G_M}) begin bad++; $display("FAIL scroll_wrap_frame got=%h want=%h", hex, {G_S, G_I, G_A, G_M}); end
        total++; if (wrap_pulse !== 1'b1) begin bad++; $display("FAIL scroll_wrap_pulse got=%b want=1", wrap_pulse); end
      end
    end
    total++; if (n_wrap !== 1) begin bad++; $display("FAIL scroll_wrap_count got=%0d want=1", n_wrap); end
  endtask

  task automatic test_error;
    do_load(3'd2);
    wait_edges(1);
    total++; if (hex !== {G__, G_E, G_r, G_r}) begin bad++; $display("FAIL err_on got=%h want=%h", hex, {G__, G_E, G_r, G_r}); end
    total++; if (scrolling !== 1'b0) begin bad++; $display("FAIL err_scrolling got=%b want=0", scrolling); end
    wait_edges(4);
    total++; if (hex !== 28'hFFFFFFF) begin bad++; $display("FAIL err_off got=%h want=%h", hex, 28'hFFFFFFF); end
    wait_edges(4);
    total++; if (hex !== {G__, G_E, G_r, G_r}) begin bad++; $display("FAIL err_on2 got=%h want=%h", hex, {G__, G_E, G_r, G_r}); end
    total++; if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL err_wrap got=%b want=0", wrap_pulse); end
  endtask

  task automatic test_midload;
    do_load(3'd0);
    wait_edges(7);
    do_load(3'd4);
    wait_edges(1);
    total++; if (hex !== {G_F, G_O, G_L, G_D}) begin bad++; $display("FAIL midload_fold got=%h want=%h", hex, {G_F, G_O, G_L, G_D}); end
    total++; if (scrolling !== 1'b0) begin bad++; $display("FAIL midload_scrolling got=%b want=0", scrolling); end
    for (int k = 0; k < 20; k++) begin
      wait_edges(1);
      total++; if (hex !== {G_F, G_O, G_L, G_D} || wrap_pulse !== 1'b0) begin bad++; $display("FAIL midload_hold k=%0d got=%h/%b want=%h/0", k, hex, wrap_pulse, {G_F, G_O, G_L, G_D}); end
    end
  endtask

  task automatic test_sweep;
    logic [27:0] first_f [8];
    logic        exp_scr [8];
    first_f[0] = {G_S, G_I, G_A, G_M}; exp_scr[0] = 1'b1;
    first_f[1] = {G_P, G_E, G_R, G_S}; exp_scr[1] = 1'b1;
    first_f[2] = {G__, G_E, G_r, G_r}; exp_scr[2] = 1'b0;
    first_f[3] = {G_C, G_O, G_O, G_N}; exp_scr[3] = 1'b0;
    first_f[4] = {G_F, G_O, G_L, G_D}; exp_scr[4] = 1'b0;
    first_f[5] = {G_B, G_E, G_N, G_G}; exp_scr[5] = 1'b1;
    first_f[6] = {G_R, G_A, G_G, G_D}; exp_scr[6] = 1'b1;
    first_f[7] = {G__, G_E, G_r, G_r}; exp_scr[7] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      do_load(3'(c));
      wait_edges(1);
      total++; if (hex !== first_f[c]) begin bad++; $display("FAIL sweep_frame code=%0d got=%h want=%h", c, hex, first_f[c]); end
      total++; if (scrolling !== exp_scr[c]) begin bad++; $display("FAIL sweep_scrolling code=%0d got=%b want=%b", c, scrolling, exp_scr[c]); end
      for (int k = 0; k < 18; k++) begin
        wait_edges(1);
        total++; if ($isunknown({hex, scrolling, wrap_pulse})) begin bad++; $display("FAIL sweep_x code=%0d got=%h/%b/%b want=no X", c, hex, scrolling, wrap_pulse); end
      end
    end
  endtask

  task automatic test_async_reset;
    do_load(3'd1);
    wait_edges(6);
    #2 reset_n = 1'b0;
    #1;
    total++; if (hex !== 28'hFFFFFFF) begin bad++; $display("FAIL async_hex got=%h want=%h", hex, 28'hFFFFFFF); end
    total++; if (scrolling !== 1'b0) begin bad++; $display("FAIL async_scrolling got=%b want=0", scrolling); end
    total++; if (wrap_pulse !== 1'b0) begin bad++; $display("FAIL async_wrap got=%b want=0", wrap_pulse); end
    wait_edges(2);
    reset_n = 1'b1;
    wait_edges(3);
    total++; if (hex !== 28'hFFFFFFF) begin bad++; $display("FAIL async_idle got=%h want=%h", hex, 28'hFFFFFFF); end
  endtask

  initial begin
    test_reset;
    test_static;
    test_scroll;
    test_error;
    test_midload;
    test_sweep;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
